// File: rtl/text_fetch_arbiter_pkg.sv
// Shared types and defaults for the text-mode fetch arbiter.
package text_fetch_arbiter_pkg;

  localparam int unsigned DefAddrW = 14;
  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefCols  = 80;

  localparam logic [13:0] DefTextBase = 14'h0000;
  localparam logic [13:0] DefFontBase = 14'h1000;

  // Video fetch sequence; CAPT states are the RAM read-latency slots.
  typedef enum logic [2:0] {
    VIdle,
    VCode,
    VCapt,
    VGlyph,
    VCapt2
  } vstate_e;

  // Video owns the RAM port only while it is issuing a read.
  function automatic logic video_owns_ram(vstate_e st);
    return (st == VCode) || (st == VGlyph);
  endfunction

endpackage

// File: rtl/text_fetch_arbiter_if.sv
// Bundles the sync-counter, pixel-shifter, host and RAM signals of the arbiter.
interface text_fetch_arbiter_if
  import text_fetch_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
);

  // Video request side
  logic              video_start;
  logic [6:0]        col;
  logic [5:0]        row;
  logic [2:0]        line;
  logic [DATA_W-1:0] glyph;
  logic              glyph_valid;
  logic              overrun;

  // Host side
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;

  // RAM port
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter view
  modport master (
    input  video_start, col, row, line,
    output glyph, glyph_valid, overrun,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata, host_rvalid,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  // Environment view (counters, shifter, host, RAM)
  modport slave (
    output video_start, col, row, line,
    input  glyph, glyph_valid, overrun,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata, host_rvalid,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/text_fetch_arbiter_vram_sp.sv
// Single-port synchronous VRAM: one access per cycle, read data one cycle later.
module vram_sp
  import text_fetch_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Write or registered read; read data holds when not reading.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/text_fetch_arbiter.sv
// Text-mode scanout sequencer sharing a single-port VRAM with a host port.
// Per cell: read char code, read glyph row, present the byte to the shifter.
// Every RAM cycle the video fetch does not use goes to a pending host request.
module text_fetch_arbiter
  import text_fetch_arbiter_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DefAddrW,
  parameter int unsigned       DATA_W    = DefDataW,
  parameter int unsigned       COLS      = DefCols,
  parameter logic [ADDR_W-1:0] TEXT_BASE = ADDR_W'(DefTextBase),
  parameter logic [ADDR_W-1:0] FONT_BASE = ADDR_W'(DefFontBase)
) (
  input logic                  clk_base,
  input logic                  rst_n,
  text_fetch_arbiter_if.master bus_io
);

  vstate_e state_q, state_d;

  logic [6:0]        col_q;
  logic [5:0]        row_q;
  logic [2:0]        line_q;
  logic [DATA_W-1:0] code_q;
  logic [DATA_W-1:0] glyph_q;
  logic              glyph_valid_q;
  logic              overrun_q;
  logic [DATA_W-1:0] host_rdata_q;
  // Last issuer: 1 when the previous RAM cycle was a host read, so ram_rdata belongs to the host.
  logic              last_host_rd_q;

  logic              host_issue;
  logic [ADDR_W-1:0] code_addr;
  logic [ADDR_W-1:0] glyph_addr;

  // Host wins any cycle video is not issuing; gated so nothing reaches the RAM during reset.
  assign host_issue = rst_n && bus_io.host_req && !video_owns_ram(state_q);

  // Address generation, both wrap modulo 2^ADDR_W.
  assign code_addr  = TEXT_BASE + ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
  assign glyph_addr = FONT_BASE + ADDR_W'({code_q, line_q});

  // Next-state: fixed five-step fetch, started only from idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      VIdle:   if (bus_io.video_start) state_d = VCode;
      VCode:   state_d = VCapt;
      VCapt:   state_d = VGlyph;
      VGlyph:  state_d = VCapt2;
      VCapt2:  state_d = VIdle;
      default: state_d = VIdle;
    endcase
  end

  // RAM port mux: video address in its read states, otherwise the host request.
  always_comb begin
    bus_io.ram_en    = 1'b0;
    bus_io.ram_we    = 1'b0;
    bus_io.ram_addr  = '0;
    bus_io.ram_wdata = '0;
    if (rst_n) begin
      if (state_q == VCode) begin
        bus_io.ram_en   = 1'b1;
        bus_io.ram_addr = code_addr;
      end else if (state_q == VGlyph) begin
        bus_io.ram_en   = 1'b1;
        bus_io.ram_addr = glyph_addr;
      end else if (bus_io.host_req) begin
        bus_io.ram_en    = 1'b1;
        bus_io.ram_we    = bus_io.host_we;
        bus_io.ram_addr  = bus_io.host_addr;
        bus_io.ram_wdata = bus_io.host_wdata;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_base or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= VIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Video datapath: cell latch, code/glyph capture, valid pulse and sticky overrun.
  always_ff @(posedge clk_base or negedge rst_n) begin
    if (!rst_n) begin
      col_q         <= '0;
      row_q         <= '0;
      line_q        <= '0;
      code_q        <= '0;
      glyph_q       <= '0;
      glyph_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      glyph_valid_q <= 1'b0;
      if (bus_io.video_start) begin
        if (state_q == VIdle) begin
          col_q  <= bus_io.col;
          row_q  <= bus_io.row;
          line_q <= bus_io.line;
        end else begin
          overrun_q <= 1'b1;
        end
      end
      if (state_q == VCapt) begin
        code_q <= bus_io.ram_rdata;
      end
      if (state_q == VCapt2) begin
        glyph_q       <= bus_io.ram_rdata;
        glyph_valid_q <= 1'b1;
      end
    end
  end

  // Host read tracking: remember a read issue, then hold its data after the valid cycle.
  always_ff @(posedge clk_base or negedge rst_n) begin
    if (!rst_n) begin
      last_host_rd_q <= 1'b0;
      host_rdata_q   <= '0;
    end else begin
      last_host_rd_q <= host_issue && !bus_io.host_we;
      if (last_host_rd_q) begin
        host_rdata_q <= bus_io.ram_rdata;
      end
    end
  end

  assign bus_io.glyph       = glyph_q;
  assign bus_io.glyph_valid = glyph_valid_q;
  assign bus_io.overrun     = overrun_q;
  assign bus_io.host_ack    = host_issue;
  assign bus_io.host_rvalid = last_host_rd_q;
  // Read data is visible in the rvalid cycle itself, then held.
  assign bus_io.host_rdata  = last_host_rd_q ? bus_io.ram_rdata : host_rdata_q;

endmodule

// File: tb/tb_text_fetch_arbiter.sv
// Self-checking bench for text_fetch_arbiter with a behavioural VRAM.
module tb_text_fetch_arbiter;
  import text_fetch_arbiter_pkg::*;

  logic clk_base = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk_base = ~clk_base;

  text_fetch_arbiter_if bus ();

  text_fetch_arbiter u_dut (
    .clk_base (clk_base),
    .rst_n    (rst_n),
    .bus_io   (bus)
  );

  vram_sp u_ram (
    .clk_i   (clk_base),
    .en_i    (bus.ram_en),
    .we_i    (bus.ram_we),
    .addr_i  (bus.ram_addr),
    .wdata_i (bus.ram_wdata),
    .rdata_o (bus.ram_rdata)
  );

  int total = 0;
  int bad   = 0;
  int gv_cnt = 0;

  logic [7:0] mem_model [int];
  logic [7:0] glyph_exp [$];
  logic [7:0] rdata_exp [$];

  // Count glyph pulses; scoreboard host read data.
  always @(negedge clk_base) begin
    if (bus.glyph_valid === 1'b1) gv_cnt++;
    if (bus.host_rvalid === 1'b1) begin
      total++;
      if (rdata_exp.size() == 0) begin
        bad++;
        $display("FAIL host_rdata_unexpected: got rvalid with data %h, required no rvalid",
                 bus.host_rdata);
      end else begin
        logic [7:0] e;
        e = rdata_exp.pop_front();
        if (bus.host_rdata !== e) begin
          bad++;
          $display("FAIL host_rdata: got %h, required %h", bus.host_rdata, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_base);
    #1;
  endtask

  // Issue one host access; returns whether it was acked and how many cycles it waited.
  task automatic host_access(input bit we, input logic [13:0] a, input logic [7:0] d,
                             output bit ok, output int waited);
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = a;
    bus.host_wdata = d;
    ok     = 1'b0;
    waited = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_base);
      if (bus.host_ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
      waited++;
    end
    if (ok) begin
      if (we) mem_model[int'(a)] = d;
      else    rdata_exp.push_back(mem_model[int'(a)]);
      tick();
    end
    bus.host_req = 1'b0;
  endtask

  // Present video_start for one edge; optionally queue the expected glyph from the model.
  task automatic start_fetch(input logic [6:0] c, input logic [5:0] r, input logic [2:0] l,
                             input bit expect_glyph);
    logic [13:0] ca;
    logic [13:0] ga;
    logic [7:0]  code;
    bus.video_start = 1'b1;
    bus.col  = c;
    bus.row  = r;
    bus.line = l;
    tick();
    bus.video_start = 1'b0;
    if (expect_glyph) begin
      ca   = 14'(r) * 14'd80 + 14'(c);
      code = mem_model[int'(ca)];
      ga   = 14'h1000 + {3'b000, code, l};
      glyph_exp.push_back(mem_model[int'(ga)]);
    end
  endtask

  task automatic test_reset();
    bit ok;
    int waited;
    rst_n = 1'b0;
    #2;
    total++;
    if ({bus.glyph, bus.glyph_valid, bus.overrun, bus.host_ack, bus.host_rvalid, bus.host_rdata,
         bus.ram_en, bus.ram_we} !== 22'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, required 0", {bus.glyph, bus.glyph_valid,
               bus.overrun, bus.host_ack, bus.host_rvalid, bus.host_rdata, bus.ram_en,
               bus.ram_we});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    // Mid-run: fetch under way plus an in-flight host read.
    start_fetch(7'd0, 6'd0, 3'd0, 1'b0);
    tick();
    bus.host_req = 1'b1;
    bus.host_we  = 1'b0;
    bus.host_addr = 14'h0000;
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.host_rvalid !== 1'b0 || bus.ram_en !== 1'b0 || bus.host_ack !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: got rvalid=%b ram_en=%b ack=%b, required 0 0 0",
               bus.host_rvalid, bus.ram_en, bus.host_ack);
    end
    total++;
    if (bus.glyph_valid !== 1'b0 || bus.overrun !== 1'b0 || bus.host_rdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_async_data: got gv=%b ovr=%b rdata=%h, required 0 0 00",
               bus.glyph_valid, bus.overrun, bus.host_rdata);
    end
    bus.host_req = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_base);
      total++;
      if (bus.ram_en !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_reset: got ram_en=%b, required 0", bus.ram_en);
      end
      tick();
    end
    host_access(1'b1, 14'h0010, 8'h11, ok, waited);
    total++;
    if (!ok || waited != 0) begin
      bad++;
      $display("FAIL idle_host_ack: got ok=%0d waited=%0d, required 1 0", ok, waited);
    end
  endtask

  task automatic test_fetch();
    bit ok;
    int waited;
    logic [7:0] old_glyph;
    host_access(1'b1, 14'h00A2, 8'h41, ok, waited);
    host_access(1'b1, 14'h120B, 8'hC6, ok, waited);
    start_fetch(7'd2, 6'd2, 3'd3, 1'b1);
    @(negedge clk_base);
    total++;
    if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 14'h00A2) begin
      bad++;
      $display("FAIL code_addr: got en=%b we=%b addr=%h, required 1 0 00a2",
               bus.ram_en, bus.ram_we, bus.ram_addr);
    end
    tick();
    tick();
    @(negedge clk_base);
    total++;
    if (bus.ram_en !== 1'b1 || bus.ram_addr !== 14'h120B) begin
      bad++;
      $display("FAIL glyph_addr: got en=%b addr=%h, required 1 120b", bus.ram_en, bus.ram_addr);
    end
    tick();
    @(negedge clk_base);
    total++;
    if (bus.glyph_valid !== 1'b0) begin
      bad++;
      $display("FAIL glyph_early: got glyph_valid=%b, required 0", bus.glyph_valid);
    end
    tick();
    @(negedge clk_base);
    total++;
    if (bus.glyph_valid !== 1'b1 || glyph_exp.size() == 0) begin
      bad++;
      $display("FAIL glyph_latency: got glyph_valid=%b, required 1", bus.glyph_valid);
    end else begin
      logic [7:0] e;
      e = glyph_exp.pop_front();
      if (bus.glyph !== e) begin
        bad++;
        $display("FAIL glyph_value: got %h, required %h", bus.glyph, e);
      end
    end
    old_glyph = bus.glyph;
    tick();
    @(negedge clk_base);
    total++;
    if (bus.glyph_valid !== 1'b0 || bus.glyph !== 8'hC6) begin
      bad++;
      $display("FAIL glyph_hold: got gv=%b glyph=%h (prev %h), required 0 c6",
               bus.glyph_valid, bus.glyph, old_glyph);
    end
    tick();
  endtask

  task automatic test_host();
    bit ok;
    int waited;
    host_access(1'b1, 14'h0300, 8'h5A, ok, waited);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL host_write_ack: got ok=%0d, required 1", ok);
    end
    @(negedge clk_base);
    total++;
    if (bus.host_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL write_no_rvalid: got rvalid=%b, required 0", bus.host_rvalid);
    end
    tick();
    host_access(1'b0, 14'h0300, 8'h00, ok, waited);
    @(negedge clk_base);
    total++;
    if (!ok || bus.host_rvalid !== 1'b1) begin
      bad++;
      $display("FAIL host_read_rvalid: got ok=%0d rvalid=%b, required 1 1", ok, bus.host_rvalid);
    end
    tick();
    @(negedge clk_base);
    total++;
    if (bus.host_rvalid !== 1'b0 || bus.host_rdata !== 8'h5A) begin
      bad++;
      $display("FAIL rdata_hold: got rvalid=%b rdata=%h, required 0 5a",
               bus.host_rvalid, bus.host_rdata);
    end
    tick();
    // Back-to-back reads in consecutive idle cycles.
    host_access(1'b0, 14'h0300, 8'h00, ok, waited);
    host_access(1'b0, 14'h00A2, 8'h00, ok, waited);
    total++;
    if (!ok || waited != 0) begin
      bad++;
      $display("FAIL back_to_back: got ok=%0d waited=%0d, required 1 0", ok, waited);
    end
    tick();
  endtask

  task automatic test_host_during_fetch();
    bit ok;
    int waited;
    bit exp_ack [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit prev_ack;
    host_access(1'b1, 14'h0400, 8'h77, ok, waited);
    tick();
    prev_ack = 1'b0;
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 14'h0400;
    bus.video_start = 1'b1;
    bus.col  = 7'd2;
    bus.row  = 6'd2;
    bus.line = 3'd3;
    glyph_exp.push_back(8'hC6);
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk_base);
      total++;
      if (bus.host_ack !== exp_ack[cyc] || bus.host_rvalid !== prev_ack) begin
        bad++;
        $display("FAIL share_ack[%0d]: got ack=%b rvalid=%b, required %b %b",
                 cyc, bus.host_ack, bus.host_rvalid, exp_ack[cyc], prev_ack);
      end
      if (bus.host_ack === 1'b1) rdata_exp.push_back(8'h77);
      if (cyc == 1 || cyc == 3) begin
        total++;
        if (bus.ram_addr !== (cyc == 1 ? 14'h00A2 : 14'h120B) || bus.ram_we !== 1'b0) begin
          bad++;
          $display("FAIL video_priority[%0d]: got addr=%h we=%b", cyc, bus.ram_addr, bus.ram_we);
        end
      end
      total++;
      if (bus.glyph_valid !== (cyc == 5)) begin
        bad++;
        $display("FAIL share_glyph_timing[%0d]: got %b, required %b",
                 cyc, bus.glyph_valid, (cyc == 5));
      end else if (cyc == 5) begin
        logic [7:0] e;
        e = glyph_exp.pop_front();
        if (bus.glyph !== e) begin
          bad++;
          $display("FAIL share_glyph_value: got %h, required %h", bus.glyph, e);
        end
      end
      prev_ack = bus.host_ack;
      tick();
      bus.video_start = 1'b0;
    end
    bus.host_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_overrun();
    int gv_before;
    int seen;
    gv_before = gv_cnt;
    seen = 0;
    start_fetch(7'd2, 6'd2, 3'd3, 1'b1);
    tick();
    bus.video_start = 1'b1;
    bus.col = 7'd9;
    bus.row = 6'd9;
    @(negedge clk_base);
    total++;
    if (bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_early: got %b, required 0", bus.overrun);
    end
    tick();
    bus.video_start = 1'b0;
    @(negedge clk_base);
    total++;
    if (bus.overrun !== 1'b1 || bus.ram_addr !== 14'h120B) begin
      bad++;
      $display("FAIL overrun_set: got ovr=%b addr=%h, required 1 120b", bus.overrun, bus.ram_addr);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk_base);
      if (bus.glyph_valid === 1'b1) begin
        seen++;
        total++;
        if (glyph_exp.size() == 0 || bus.glyph !== glyph_exp[0]) begin
          bad++;
          $display("FAIL overrun_glyph: got %h, required c6", bus.glyph);
        end
        if (glyph_exp.size() != 0) void'(glyph_exp.pop_front());
      end
    end
    total++;
    if (gv_cnt - gv_before != 1 || seen != 1 || bus.overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_single: got pulses=%0d ovr=%b, required 1 1",
               gv_cnt - gv_before, bus.overrun);
    end
    tick();
  endtask

  task automatic test_reset_in_glyph();
    bit ok;
    int waited;
    int gv_before;
    int n;
    host_access(1'b1, 14'h00F5, 8'h10, ok, waited);
    host_access(1'b1, 14'h1081, 8'h3C, ok, waited);
    start_fetch(7'd5, 6'd3, 3'd1, 1'b0);
    tick();
    tick();
    total++;
    if (bus.ram_addr !== 14'h1081) begin
      bad++;
      $display("FAIL pre_reset_glyph_addr: got %h, required 1081", bus.ram_addr);
    end
    gv_before = gv_cnt;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    total++;
    if (gv_cnt != gv_before || bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL abandoned_fetch: got pulses=%0d ovr=%b, required 0 0",
               gv_cnt - gv_before, bus.overrun);
    end
    start_fetch(7'd5, 6'd3, 3'd1, 1'b1);
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_base);
      if (bus.glyph_valid === 1'b1) begin
        n = i;
        break;
      end
      tick();
    end
    total++;
    if (n != 5 || glyph_exp.size() == 0) begin
      bad++;
      $display("FAIL refetch_latency: got cycle %0d, required 5", n);
    end else begin
      logic [7:0] e;
      e = glyph_exp.pop_front();
      total++;
      if (bus.glyph !== e) begin
        bad++;
        $display("FAIL refetch_glyph: got %h, required %h", bus.glyph, e);
      end
    end
    tick();
    tick();
  endtask

  task automatic test_drain();
    total++;
    if (glyph_exp.size() != 0 || rdata_exp.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d glyph and %0d read entries left, required 0 0",
               glyph_exp.size(), rdata_exp.size());
    end
  endtask

  initial begin
    bus.video_start = 1'b0;
    bus.col        = '0;
    bus.row        = '0;
    bus.line       = '0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    test_reset();
    test_fetch();
    test_host();
    test_host_during_fetch();
    test_overrun();
    test_reset_in_glyph();
    test_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
